// File: rtl/axi_ram_slave_if.sv
// AXI3 single-beat read/write channel bundle between a master and the RAM responder.
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arvalid, rready,
        input  awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );

    modport master (
        output arid, araddr, arvalid, rready,
        output awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_ram_slave.sv
// Single-beat AXI3 RAM responder: independent read and write FSMs over a
// word-addressed byte-strobed array, with programmable response latency.
module axi_ram_slave #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_ram_slave_if.slave   bus
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] RD_INIT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_INIT = 4'(WR_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;

    logic [31:0] ram_q [DEPTH];

    logic [ADDR_W-1:0] ar_word;
    logic [ADDR_W-1:0] aw_word;
    logic              unused_addr_bits;

    // Byte offset and high address bits are dropped so the space wraps.
    assign ar_word = bus.araddr[ADDR_W+1:2];
    assign aw_word = bus.awaddr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.araddr[31:ADDR_W+2], bus.araddr[1:0],
                                bus.awaddr[31:ADDR_W+2], bus.awaddr[1:0]};

    rd_state_t         rd_state_q, rd_state_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic [3:0]        arid_q, arid_d;
    logic [ADDR_W-1:0] ar_idx_q, ar_idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_idx_sel;
    logic [31:0]       rd_word;
    logic [31:0]       rd_merged;

    wr_state_t         wr_state_q, wr_state_d;
    logic [3:0]        wr_cnt_q, wr_cnt_d;
    logic [3:0]        awid_q, awid_d;
    logic [ADDR_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wr_commit;
    logic              ram_we;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        arid_d     = arid_q;
        ar_idx_d   = ar_idx_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    arid_d   = bus.arid;
                    ar_idx_d = ar_word;
                    rd_cnt_d = RD_INIT;
                    if (RD_LATENCY <= 1) begin
                        rd_state_d = R_RESP;
                        rd_load    = 1'b1;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q <= 4'd1) begin
                    rd_state_d = R_RESP;
                    rd_load    = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // A single-cycle latency read samples the live address in the handshake cycle.
    assign rd_idx_sel = (rd_state_q == R_IDLE) ? ar_word : ar_idx_q;
    assign rd_word    = ram_q[rd_idx_sel];

    // Bytes committed on the same edge the read loads win over stale RAM contents.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_merged[gi*8 +: 8] =
            (ram_we && wr_strb[gi] && (wr_idx == rd_idx_sel)) ?
            wr_data[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end

    assign rdata_d = rd_load ? rd_merged : rdata_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        awid_d     = awid_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_commit  = 1'b0;
        wr_idx     = aw_word;
        wr_data    = bus.wdata;
        wr_strb    = bus.wstrb;
        case (wr_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    awid_d   = bus.awid;
                    aw_idx_d = aw_word;
                end
                if (bus.wvalid) begin
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                end
                if (bus.awvalid && bus.wvalid) begin
                    wr_commit  = 1'b1;
                    wr_cnt_d   = WR_INIT;
                    wr_state_d = W_RESP;
                end else if (bus.awvalid) begin
                    wr_state_d = W_HAVE_AW;
                end else if (bus.wvalid) begin
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                wr_idx = aw_idx_q;
                if (bus.wvalid) begin
                    wr_commit  = 1'b1;
                    wr_cnt_d   = WR_INIT;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                wr_data = wdata_q;
                wr_strb = wstrb_q;
                if (bus.awvalid) begin
                    awid_d     = bus.awid;
                    aw_idx_d   = aw_word;
                    wr_commit  = 1'b1;
                    wr_cnt_d   = WR_INIT;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (wr_cnt_q != 4'd0) begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end else if (bus.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign ram_we = wr_commit && aresetn;

    always_ff @(posedge aclk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    ram_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= 4'd0;
            arid_q     <= 4'd0;
            ar_idx_q   <= '0;
            rdata_q    <= 32'd0;
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= 4'd0;
            awid_q     <= 4'd0;
            aw_idx_q   <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            arid_q     <= arid_d;
            ar_idx_q   <= ar_idx_d;
            rdata_q    <= rdata_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            awid_q     <= awid_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign bus.arready = (rd_state_q == R_IDLE);
    assign bus.rvalid  = (rd_state_q == R_RESP);
    assign bus.rid     = arid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = 1'b1;
    assign bus.awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
    assign bus.wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
    assign bus.bid     = awid_q;
    assign bus.bresp   = 2'b00;
    assign bus.bvalid  = (wr_state_q == W_RESP) && (wr_cnt_q == 4'd0);

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed scoreboard bench for axi_ram_slave: drivers queue expected
// responses, a monitor checks them whenever rvalid or bvalid is presented.
module tb_axi_ram_slave;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic clk;
    logic aresetn;
    int   cyc;
    int   errors;
    int   checks;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];
    logic rv_prev;
    logic bv_prev;

    axi_ram_slave_if bus();

    axi_ram_slave #(.ADDR_W(12), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (aresetn) begin
            if (bus.rvalid) begin
                if (rq.size() == 0) begin
                    tmo("r_unexpected");
                end else begin
                    if (!rv_prev) chk("r_latency", cyc, rq[0].cyc);
                    chk("rdata", bus.rdata, rq[0].data);
                    chk("rid", {28'd0, bus.rid}, {28'd0, rq[0].id});
                    chk("arready_busy", {31'd0, bus.arready}, 32'd0);
                    if (bus.rready) begin
                        $display("read  id=%0d data=%h cycle=%0d", bus.rid, bus.rdata, cyc);
                        void'(rq.pop_front());
                    end
                end
            end
            if (bus.bvalid) begin
                if (bq.size() == 0) begin
                    tmo("b_unexpected");
                end else begin
                    if (!bv_prev) chk("b_latency", cyc, bq[0].cyc);
                    chk("bid", {28'd0, bus.bid}, {28'd0, bq[0].id});
                    chk("ready_in_bresp", {30'd0, bus.awready, bus.wready}, 32'd0);
                    if (bus.bready) begin
                        $display("write id=%0d resp cycle=%0d", bus.bid, cyc);
                        void'(bq.pop_front());
                    end
                end
            end
        end
        rv_prev = bus.rvalid;
        bv_prev = bus.bvalid;
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] exp);
        int t;
        @(posedge clk); #1;
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.araddr  = addr;
        t = 0;
        @(negedge clk);
        while (!bus.arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.arready) tmo("ar_handshake");
        else rq.push_back('{id: id, data: exp, cyc: cyc + RD_LAT});
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // mode 0: AW and W together; 1: W three cycles ahead; 2: AW three cycles ahead
    task automatic send_wr(input logic [3:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int mode);
        int c;
        @(posedge clk); #1;
        bus.awid   = id;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        if (mode == 0) begin
            bus.awvalid = 1'b1;
            bus.wvalid  = 1'b1;
            @(negedge clk);
            chk("idle_readies", {30'd0, bus.awready, bus.wready}, 32'd3);
            c = cyc;
        end else begin
            if (mode == 1) bus.wvalid = 1'b1;
            else           bus.awvalid = 1'b1;
            @(negedge clk);
            chk("first_ready", {31'd0, (mode == 1) ? bus.wready : bus.awready}, 32'd1);
            @(posedge clk); #1;
            bus.wvalid  = 1'b0;
            bus.awvalid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                if (mode == 1) chk("wready_wait", {31'd0, bus.wready}, 32'd0);
                else           chk("awready_wait", {31'd0, bus.awready}, 32'd0);
                @(posedge clk); #1;
            end
            if (mode == 1) bus.awvalid = 1'b1;
            else           bus.wvalid = 1'b1;
            @(negedge clk);
            chk("second_ready", {31'd0, (mode == 1) ? bus.awready : bus.wready}, 32'd1);
            c = cyc;
        end
        bq.push_back('{id: id, data: 32'd0, cyc: c + WR_LAT});
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            tmo("drain");
            rq.delete();
            bq.delete();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_arready", {31'd0, bus.arready}, 32'd1);
        chk("rst_awready", {31'd0, bus.awready}, 32'd1);
        chk("rst_wready",  {31'd0, bus.wready},  32'd1);
        chk("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
        chk("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
        chk("rst_rid",     {28'd0, bus.rid},     32'd0);
        chk("rst_bid",     {28'd0, bus.bid},     32'd0);
        chk("rst_rdata",   bus.rdata,            32'd0);
    endtask

    initial begin
        int t;
        int c;
        errors  = 0;
        checks  = 0;
        rv_prev = 1'b0;
        bv_prev = 1'b0;
        aresetn = 1'b0;
        bus.arid = 4'd0;  bus.araddr = 32'd0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awid = 4'd0;  bus.awaddr = 32'd0; bus.awvalid = 1'b0;
        bus.wdata = 32'd0; bus.wstrb = 4'd0;  bus.wvalid = 1'b0;  bus.bready = 1'b1;

        #12;
        chk_reset_outputs();
        chk("rst_rresp_rlast", {29'd0, bus.rresp, bus.rlast}, 32'd1);
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Basic write then read
        send_wr(4'd3, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0);
        wait_idle();
        send_ar(4'd1, 32'h0000_0100, 32'hDEAD_BEEF);
        wait_idle();

        // Split address/data phases in both orders
        send_wr(4'd5, 32'h0000_0104, 32'h1234_5678, 4'hF, 1);
        wait_idle();
        send_ar(4'd2, 32'h0000_0104, 32'h1234_5678);
        send_wr(4'd6, 32'h0000_0108, 32'hCAFE_F00D, 4'hF, 2);
        wait_idle();
        send_ar(4'd3, 32'h0000_0108, 32'hCAFE_F00D);
        wait_idle();

        // Partial strobes, empty strobe, and address wrap
        send_wr(4'd7, 32'h0000_010C, 32'hAAAA_AAAA, 4'hF, 0);
        wait_idle();
        send_wr(4'd8, 32'h0000_010C, 32'h1122_3344, 4'b0101, 0);
        wait_idle();
        send_ar(4'd4, 32'h0000_010C, 32'hAA22_AA44);
        wait_idle();
        send_wr(4'd9, 32'h0000_010E, 32'hFFFF_FFFF, 4'b0000, 1);
        wait_idle();
        send_ar(4'd5, 32'h0000_410F, 32'hAA22_AA44);
        wait_idle();

        // Backpressure on R
        bus.rready = 1'b0;
        send_ar(4'd6, 32'h0000_0100, 32'hDEAD_BEEF);
        t = 0;
        while (!bus.rvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rvalid) tmo("rvalid_rise");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_arready", {31'd0, bus.arready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arready_return", {31'd0, bus.arready}, 32'd1);
        wait_idle();

        // Write commits on the edge the read enters R_RESP
        send_wr(4'd1, 32'h0000_0200, 32'h7777_7777, 4'hF, 0);
        wait_idle();
        @(posedge clk); #1;
        bus.arvalid = 1'b1;
        bus.arid    = 4'd7;
        bus.araddr  = 32'h0000_0200;
        @(negedge clk);
        chk("coll_arready", {31'd0, bus.arready}, 32'd1);
        c = cyc;
        rq.push_back('{id: 4'd7, data: 32'h0000_0005, cyc: c + RD_LAT});
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.awid    = 4'd8;
        bus.awaddr  = 32'h0000_0200;
        bus.wdata   = 32'h0000_0005;
        bus.wstrb   = 4'hF;
        @(negedge clk);
        chk("coll_wready", {30'd0, bus.awready, bus.wready}, 32'd3);
        bq.push_back('{id: 4'd8, data: 32'd0, cyc: cyc + WR_LAT});
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_idle();

        // Reset while in W_RESP and R_WAIT
        bus.bready = 1'b0;
        send_wr(4'd9, 32'h0000_0300, 32'h0000_0001, 4'hF, 0);
        send_ar(4'd10, 32'h0000_0100, 32'hDEAD_BEEF);
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs();
        rq.delete();
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        bus.bready = 1'b1;
        aresetn    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_valids", {30'd0, bus.rvalid, bus.bvalid}, 32'd0);
        end
        send_wr(4'd11, 32'h0000_0304, 32'h0BAD_F00D, 4'hF, 0);
        wait_idle();
        send_ar(4'd12, 32'h0000_0304, 32'h0BAD_F00D);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
Single-beat AXI3 responder backed by a word-addressed RAM array. It is the slave end for the CPU-side SRAM-to-AXI bridge and stands in for the system memory in simulation. It accepts one read and one write transaction at a time, applies byte strobes, and returns responses after a configurable latency.

Parameters:
ADDR_W, 12, word-index width; RAM holds 2**ADDR_W 32-bit words.
RD_LATENCY, 2, cycles from AR handshake to rvalid assertion; legal range 1..15.
WR_LATENCY, 1, cycles from write commit to bvalid assertion; legal range 1..15.

Ports:
aclk  in  1  clock; all state changes on the rising edge.
aresetn  in  1  asynchronous active-low reset.
arid  in  4  read ID; latched at the AR handshake.
araddr  in  32  read byte address.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
rid  out  4  latched arid.
rdata  out  32  read data word.
rresp  out  2  always 2'b00 (OKAY).
rlast  out  1  always 1.
rvalid  out  1  read data valid.
rready  in  1  master accepts read data.
awid  in  4  write ID; latched at the AW handshake.
awaddr  in  32  write byte address.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
wdata  in  32  write data.
wstrb  in  4  byte enables; bit i enables byte lane i.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
bid  out  4  latched awid.
bresp  out  2  always 2'b00.
bvalid  out  1  write response valid.
bready  in  1  master accepts the write response.

Behaviour:
- Reset: arready=1, awready=1, wready=1; rvalid=0, bvalid=0, rid=0, bid=0, rdata=0. Both FSMs go to idle. RAM contents are not reset.
- Asserting aresetn low mid-transaction aborts all in-flight transactions; no response is issued for them.
- Word index = addr[ADDR_W+1:2]. Address bits [1:0] and bits above ADDR_W+1 are ignored, so the address space wraps.
- Read FSM has three states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid, latch arid and the word index, load a counter with RD_LATENCY-1, and go to R_WAIT. If RD_LATENCY=1, go directly to R_RESP.
  - R_WAIT: arready=0. Decrement the counter each cycle; when it reaches 0, go to R_RESP.
  - Every transition into R_RESP loads rdata from the RAM. rvalid rises exactly RD_LATENCY cycles after the AR handshake cycle.
  - R_RESP: rvalid=1. rid and rdata stay stable until rready. On rready, drop rvalid and return to R_IDLE. arready reasserts the following cycle, so there are no back-to-back ARs.
- Write FSM has four states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=1, wready=1. If AW and W handshake in the same cycle, commit and go to W_RESP. If only AW handshakes, go to W_HAVE_AW. If only W handshakes, go to W_HAVE_W.
  - W_HAVE_AW: awready=0, wready=1. On wvalid, commit and go to W_RESP.
  - W_HAVE_W: awready=1, wready=0. On awvalid, commit and go to W_RESP.
  - Commit: in the cycle the second handshake completes, write each byte lane whose wstrb bit is set, using the latched or live address and data. wstrb=0 commits no bytes but still produces a response.
  - W_RESP: both readies are 0. bvalid rises WR_LATENCY cycles after the commit cycle and holds until bready, then the FSM returns to W_IDLE.
- Read/write ordering:
  - A write whose commit edge is at or before the edge that enters R_RESP is visible in that read's rdata.
  - A write committing on the same edge the read enters R_RESP is also visible; the write takes priority.
- The read and write FSMs are independent and may be active simultaneously.

Test Plan:
- Write 0xDEADBEEF to 0x100 with wstrb=4'hF, AW and W in the same cycle -> bvalid exactly 1 cycle after commit; bid equals awid. Then read 0x100 with arid=1 -> rvalid exactly 2 cycles after the AR handshake, rdata=0xDEADBEEF, rid=1.
- Addresses: W arrives 3 cycles before AW -> wready=0 while waiting, commit happens on the AW cycle. Repeat with AW arriving first -> same committed result.
- Partial write wstrb=4'b0101, wdata=0x11223344 over an existing 0xAAAAAAAA -> a subsequent read returns 0xAA22AA44.
- Hold rready=0 for 5 cycles during R_RESP -> rvalid, rdata and rid stay stable and arready stays 0. Drop rready-hold: read completes and arready returns to 1 the next cycle.
- Same-cycle collision: with RD_LATENCY=2, issue an AR to 0x200, then commit a write of 0x5 to 0x200 on the edge the read enters R_RESP -> rdata=0x5.
- Assert aresetn low while in W_RESP and R_WAIT -> all outputs take their reset values asynchronously. No bvalid or rvalid appears after reset release; a fresh transaction completes normally.
